// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback path: register address, data word,
// and the writeback request bundle used by both producers.
package regfile_wb_arbiter_pkg;
  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic     valid;
    regaddr_t addr;
    word_t    data;
  } wb_req_t;

  localparam regaddr_t REG_X0 = 5'd0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector for long-latency results still in flight; answers the
// two hazard queries and the issue-legality query combinationally.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     set_i,
  input  regaddr_t set_addr_i,
  input  logic     clr_i,
  input  regaddr_t clr_addr_i,
  input  regaddr_t ra_addr_i,
  input  regaddr_t rb_addr_i,
  input  regaddr_t issue_addr_i,
  output logic     ra_busy_o,
  output logic     rb_busy_o,
  output logic     issue_ready_o
);
  logic [31:0] busy_q, busy_d;

  // Set is applied after clear so a same-address collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    busy_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign ra_busy_o     = busy_q[ra_addr_i];
  assign rb_busy_o     = busy_q[rb_addr_i];
  assign issue_ready_o = !busy_q[issue_addr_i];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the unstallable pipeline
// writeback and a one-entry holding register fed by the long-latency unit.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_stall_o,
  input  logic        ll_valid_i,
  input  logic [4:0]  ll_addr_i,
  input  logic [31:0] ll_data_i,
  output logic        ll_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_addr_i,
  output logic        issue_ready_o,
  input  logic [4:0]  ra_addr_i,
  input  logic [4:0]  rb_addr_i,
  output logic        ra_busy_o,
  output logic        rb_busy_o,
  output logic        wr_enable_o,
  output logic [4:0]  wr_addr_o,
  output logic [31:0] wr_data_o
);
  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  wb_req_t    wb_req, hold_q, hold_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       wb_stall_q, wb_stall_d;
  logic       blocked, commit, ll_accept;

  assign wb_req     = '{valid: wb_valid_i, addr: wb_addr_i, data: wb_data_i};
  assign blocked    = hold_q.valid && wb_req.valid;
  assign commit     = hold_q.valid && !wb_req.valid && !reset_i;
  assign ll_ready_o = !hold_q.valid || !wb_req.valid;
  assign ll_accept  = ll_valid_i && ll_ready_o && !reset_i;

  // Pipeline always wins; the held entry only uses idle port cycles.
  assign wr_enable_o = !reset_i && (wb_req.valid || hold_q.valid);
  assign wr_addr_o   = wb_req.valid ? wb_req.addr : hold_q.addr;
  assign wr_data_o   = wb_req.valid ? wb_req.data : hold_q.data;
  assign wb_stall_o  = wb_stall_q;

  always_comb begin
    hold_d = hold_q;
    if (commit)    hold_d.valid = 1'b0;
    if (ll_accept) hold_d = '{valid: 1'b1, addr: ll_addr_i, data: ll_data_i};
  end

  // Blocked cycles are the only ones where a hold survives, so any other cycle restarts the count.
  always_comb begin
    starve_cnt_d = '0;
    wb_stall_d   = wb_stall_q;
    if (blocked) begin
      starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
      if ({1'b0, starve_cnt_q} + 5'd1 >= LIMIT) wb_stall_d = 1'b1;
    end
    if (commit) wb_stall_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q       <= '0;
      starve_cnt_q <= '0;
      wb_stall_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      starve_cnt_q <= starve_cnt_d;
      wb_stall_q   <= wb_stall_d;
    end
  end

  regfile_scoreboard u_sb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .set_i         (issue_i && !reset_i),
    .set_addr_i    (issue_addr_i),
    .clr_i         (commit),
    .clr_addr_i    (hold_q.addr),
    .ra_addr_i     (ra_addr_i),
    .rb_addr_i     (rb_addr_i),
    .issue_addr_i  (issue_addr_i),
    .ra_busy_o     (ra_busy_o),
    .rb_busy_o     (rb_busy_o),
    .issue_ready_o (issue_ready_o)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(issue_i && !issue_ready_o))
        else $error("issue to busy register x%0d", issue_addr_i);
      assert (!(wb_stall_q && wb_valid_i))
        else $error("pipeline writeback during wb_stall_o");
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: expected register-file writes are queued when stimulus is driven
// and checked in order by a write-port monitor; status outputs are checked inline.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        wb_valid_i, ll_valid_i, issue_i;
  logic [4:0]  wb_addr_i, ll_addr_i, issue_addr_i, ra_addr_i, rb_addr_i;
  logic [31:0] wb_data_i, ll_data_i;
  logic        wb_stall_o, ll_ready_o, issue_ready_o, ra_busy_o, rb_busy_o;
  logic        wr_enable_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;

  int vectors = 0;
  int miscompares = 0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_stall_o(wb_stall_o),
    .ll_valid_i(ll_valid_i), .ll_addr_i(ll_addr_i), .ll_data_i(ll_data_i),
    .ll_ready_o(ll_ready_o),
    .issue_i(issue_i), .issue_addr_i(issue_addr_i), .issue_ready_o(issue_ready_o),
    .ra_addr_i(ra_addr_i), .rb_addr_i(rb_addr_i),
    .ra_busy_o(ra_busy_o), .rb_busy_o(rb_busy_o),
    .wr_enable_o(wr_enable_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{valid: 1'b1, addr: a, data: d});
  endtask

  // Write-port monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset_i && wr_enable_o) begin
      if (exp_q.size() == 0) chk("wr_spurious", 32'(wr_enable_o), 32'd0);
      else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        chk("wr_data", wr_data_o, e.data);
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
    ll_valid_i = 0; ll_addr_i = 0; ll_data_i = 0;
    issue_i = 0; issue_addr_i = 0; ra_addr_i = 0; rb_addr_i = 0;

    // Reset state, with an (ignored) pipeline request present.
    wb_valid_i = 1'b1; wb_addr_i = 5'd6;
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_enable_o), 0);
    chk("rst_ll_ready", 32'(ll_ready_o), 1);
    chk("rst_issue_ready", 32'(issue_ready_o), 1);
    chk("rst_stall", 32'(wb_stall_o), 0);
    chk("rst_busy", {30'd0, ra_busy_o, rb_busy_o}, 0);
    @(posedge clk); #1 reset_i = 1'b0; wb_valid_i = 1'b0;

    // Long-latency write accepted, committed one cycle later.
    @(posedge clk); #1 ll_valid_i = 1; ll_addr_i = 5'd5; ll_data_i = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_accept_ready", 32'(ll_ready_o), 1);
    chk("t1_no_same_cycle_wr", 32'(wr_enable_o), 0);
    @(posedge clk); #1 ll_valid_i = 0;
    @(negedge clk);
    chk("t1_commit_wr_en", 32'(wr_enable_o), 1);
    chk("t1_ready_stays", 32'(ll_ready_o), 1);

    // Scoreboard: issue x7, busy next cycle, cleared after commit.
    @(posedge clk); #1 issue_i = 1; issue_addr_i = 5'd7; ra_addr_i = 5'd7; rb_addr_i = 5'd7;
    @(negedge clk);
    chk("t2_busy_not_yet", 32'(ra_busy_o), 0);
    @(posedge clk); #1 issue_i = 0;
    @(negedge clk);
    chk("t2_ra_busy", 32'(ra_busy_o), 1);
    chk("t2_rb_busy", 32'(rb_busy_o), 1);
    chk("t2_issue_blocked", 32'(issue_ready_o), 0);
    @(posedge clk); #1 ll_valid_i = 1; ll_addr_i = 5'd7; ll_data_i = 32'h0000_0077;
    push(5'd7, 32'h77);
    @(posedge clk); #1 ll_valid_i = 0;
    @(negedge clk);
    chk("t2_busy_during_commit", 32'(ra_busy_o), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_busy_cleared", 32'(ra_busy_o), 0);
    chk("t2_issue_ready", 32'(issue_ready_o), 1);

    // Starvation: hold x3 while the pipeline writes every cycle.
    @(posedge clk); #1 ll_valid_i = 1; ll_addr_i = 5'd3; ll_data_i = 32'h33;
    @(posedge clk); #1 ll_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      wb_valid_i = 1; wb_addr_i = 5'd10; wb_data_i = 32'h1000 + i;
      push(5'd10, 32'h1000 + i);
      @(negedge clk);
      chk("t3_blocked_ready", 32'(ll_ready_o), 0);
      chk("t3_stall_low", 32'(wb_stall_o), 0);
      @(posedge clk); #1;
    end
    wb_valid_i = 0;
    push(5'd3, 32'h33);
    @(negedge clk);
    chk("t3_stall_high", 32'(wb_stall_o), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_stall_cleared", 32'(wb_stall_o), 0);

    // Simultaneous: pipeline x1 beats held x2; x4 waits, then streams behind x2.
    @(posedge clk); #1 ll_valid_i = 1; ll_addr_i = 5'd2; ll_data_i = 32'h22;
    @(posedge clk); #1 wb_valid_i = 1; wb_addr_i = 5'd1; wb_data_i = 32'h11;
    ll_addr_i = 5'd4; ll_data_i = 32'h44;
    push(5'd1, 32'h11);
    @(negedge clk);
    chk("t4_ll_ready_low", 32'(ll_ready_o), 0);
    @(posedge clk); #1 wb_valid_i = 0;
    push(5'd2, 32'h22);
    @(negedge clk);
    chk("t4_ll_ready_back", 32'(ll_ready_o), 1);
    @(posedge clk); #1 ll_valid_i = 0;
    push(5'd4, 32'h44);

    // x0: handshake completes, write is issued, never busy.
    @(posedge clk); #1 ll_valid_i = 1; ll_addr_i = 5'd0; ll_data_i = 32'h55;
    issue_i = 1; issue_addr_i = 5'd0; ra_addr_i = 5'd0;
    push(5'd0, 32'h55);
    @(negedge clk);
    chk("t5_x0_accept", 32'(ll_ready_o), 1);
    @(posedge clk); #1 ll_valid_i = 0; issue_i = 0;
    @(negedge clk);
    chk("t5_x0_issue_ready", 32'(issue_ready_o), 1);
    chk("t5_x0_not_busy", 32'(ra_busy_o), 0);

    // Reset mid-operation: pending hold for x12 and busy[9] are discarded.
    @(posedge clk); #1 issue_i = 1; issue_addr_i = 5'd9; rb_addr_i = 5'd9;
    @(posedge clk); #1 issue_i = 0;
    ll_valid_i = 1; ll_addr_i = 5'd12; ll_data_i = 32'h99;
    wb_valid_i = 1; wb_addr_i = 5'd13; wb_data_i = 32'hA1;
    push(5'd13, 32'hA1);
    @(posedge clk); #1 ll_valid_i = 0; wb_data_i = 32'hA2;
    push(5'd13, 32'hA2);
    @(negedge clk);
    chk("t6_rb_busy_before", 32'(rb_busy_o), 1);
    #1 reset_i = 1; wb_valid_i = 0;
    #1;
    chk("t6_rb_busy_reset", 32'(rb_busy_o), 0);
    chk("t6_wr_en_reset", 32'(wr_enable_o), 0);
    @(posedge clk); #1 reset_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_ll_ready_after", 32'(ll_ready_o), 1);
    chk("wr_pending", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
